serial_frame_rx: RTL and testbench

//  Parametrised successor of the fixed-width rx: receives one-wire, idle-high serial frames

---
 rtl/serial_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/serial_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver state encoding and line-level frame constants.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to the idle line level.
module sync_2ff
  import serial_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_r <= IDLE_LVL;
      sync_r <= IDLE_LVL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/serial_frame_rx.sv
// Parametrised serial frame receiver: start bit, LSB-first payload, optional even parity, stop bit.
// Reports good frames, parity errors and framing errors as one-cycle registered pulses.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int PAYLOAD_W    = 162,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(PAYLOAD_W + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_W - 1);

  // Even parity: the payload plus its parity bit must hold an even number of ones.
  function automatic logic parity_bad(input logic [PAYLOAD_W-1:0] payload, input logic par_bit);
    return (^payload) ^ par_bit;
  endfunction

  logic                 rx_sync_s;
  rx_state_t            state_r,    state_s;
  logic [TW-1:0]        timer_r,    timer_s;
  logic [BW-1:0]        bit_cnt_r,  bit_cnt_s;
  logic [PAYLOAD_W-1:0] shift_r,    shift_s;
  logic [PAYLOAD_W-1:0] data_r,     data_s;
  logic                 par_bad_r,  par_bad_s;
  logic                 ready_r,    ready_s;
  logic                 ferr_r,     ferr_s;
  logic                 perr_r,     perr_s;
  logic                 busy_r,     busy_s;

  sync_2ff u_rx_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (rx),
    .q      (rx_sync_s)
  );

  // Next-state, timer, shift register and pulse decode
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    data_s    = data_r;
    par_bad_s = par_bad_r;
    ready_s   = 1'b0;
    ferr_s    = 1'b0;
    perr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_s = {TW{1'b0}};
        if (rx_sync_s == START_BIT) begin
          state_s   = ST_START;
          bit_cnt_s = {BW{1'b0}};
          par_bad_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Mid-bit check rejects glitches shorter than half a bit
        if (timer_r == HALF_M1) begin
          timer_s = {TW{1'b0}};
          if (rx_sync_s == START_BIT) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      ST_DATA: begin
        if (timer_r == FULL_M1) begin
          timer_s                   = {TW{1'b0}};
          shift_s                   = shift_r >> 1;
          shift_s[PAYLOAD_W-1]      = rx_sync_s;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = {BW{1'b0}};
            if (PARITY_EN != 0) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      ST_PARITY: begin
        if (timer_r == FULL_M1) begin
          timer_s   = {TW{1'b0}};
          par_bad_s = parity_bad(shift_r, rx_sync_s);
          state_s   = ST_STOP;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      ST_STOP: begin
        // A low stop bit outranks any parity mismatch
        if (timer_r == FULL_M1) begin
          timer_s = {TW{1'b0}};
          if (rx_sync_s != STOP_BIT) begin
            ferr_s  = 1'b1;
            state_s = ST_WAIT_IDLE;
          end else if (par_bad_r) begin
            perr_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            data_s  = shift_r;
            ready_s = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync_s == IDLE_LVL) begin
          if (timer_r == FULL_M1) begin
            timer_s = {TW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            timer_s = timer_r + 1'b1;
          end
        end else begin
          timer_s = {TW{1'b0}};
        end
      end
      default: begin
        state_s   = ST_IDLE;
        timer_s   = {TW{1'b0}};
        bit_cnt_s = {BW{1'b0}};
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      shift_r   <= {PAYLOAD_W{1'b0}};
      data_r    <= {PAYLOAD_W{1'b0}};
      par_bad_r <= 1'b0;
      ready_r   <= 1'b0;
      ferr_r    <= 1'b0;
      perr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      par_bad_r <= par_bad_s;
      ready_r   <= ready_s;
      ferr_r    <= ferr_s;
      perr_r    <= perr_s;
      busy_r    <= busy_s;
    end
  end

  assign data_out   = data_r;
  assign ready      = ready_r;
  assign frame_err  = ferr_r;
  assign parity_err = perr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a 16-bit parity instance and a 162-bit no-parity instance,
// checked against frame-level expectations derived from payload, parity and stop bits.
module tb_serial_frame_rx;

  localparam int CPB = 8;
  localparam int WA  = 16;
  localparam int WB  = 162;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          rx_a = 1'b1;
  logic          rx_b = 1'b1;
  logic [WA-1:0] data_a;
  logic [WB-1:0] data_b;
  logic          ready_a, ferr_a, perr_a, busy_a;
  logic          ready_b, ferr_b, perr_b, busy_b;

  int checks = 0;
  int errors = 0;
  int rdy_cnt_a = 0, perr_cnt_a = 0, ferr_cnt_a = 0, both_a = 0;
  int rdy_cnt_b = 0, perr_cnt_b = 0, ferr_cnt_b = 0;
  logic [WA-1:0] exp_a = '0;
  logic [WB-1:0] got_b[$];

  serial_frame_rx #(.PAYLOAD_W(WA), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_a (
    .clk_in(clk), .rst_in(rst_in), .rx(rx_a), .data_out(data_a),
    .ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a)
  );

  serial_frame_rx #(.PAYLOAD_W(WB), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_b (
    .clk_in(clk), .rst_in(rst_in), .rx(rx_b), .data_out(data_b),
    .ready(ready_b), .frame_err(ferr_b), .parity_err(perr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Pulse counters and captured payloads
  always @(negedge clk) begin
    if (ready_a === 1'b1) rdy_cnt_a++;
    if (perr_a === 1'b1) perr_cnt_a++;
    if (ferr_a === 1'b1) ferr_cnt_a++;
    if ((ready_a & (perr_a | ferr_a)) === 1'b1 || (perr_a & ferr_a) === 1'b1) both_a++;
    if (ready_b === 1'b1) begin rdy_cnt_b++; got_b.push_back(data_b); end
    if (perr_b === 1'b1) perr_cnt_b++;
    if (ferr_b === 1'b1) ferr_cnt_b++;
  end

  // Serialise start, payload LSB-first, optional parity, stop; cut>=0 stops half-way into that bit.
  task automatic drive_frame(input bit on_b, input logic [WB-1:0] payload, input logic par,
                             input logic stop, input int cut);
    logic bits[$];
    int w;
    w = on_b ? WB : WA;
    bits.push_back(1'b0);
    for (int i = 0; i < w; i++) bits.push_back(payload[i]);
    if (!on_b) bits.push_back(par);
    bits.push_back(stop);
    for (int i = 0; i < bits.size(); i++) begin
      if (on_b) rx_b = bits[i]; else rx_a = bits[i];
      if (i == cut) begin
        repeat (CPB / 2) @(negedge clk);
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    if (on_b) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  function automatic logic [WB-1:0] ext_a(input logic [WA-1:0] p);
    return {{(WB - WA){1'b0}}, p};
  endfunction

  task automatic test_reset();
    int bad_d = 0, bad_p = 0, bad_b = 0;
    rst_in = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_a !== '0 || data_b !== '0) bad_d++;
      if ({ready_a, ferr_a, perr_a, ready_b, ferr_b, perr_b} !== 6'b0) bad_p++;
      if ({busy_a, busy_b} !== 2'b0) bad_b++;
    end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL reset_data bad_cycles=%0d expected 0", bad_d); end
    checks++; if (bad_p != 0) begin errors++; $display("FAIL reset_pulses bad_cycles=%0d expected 0", bad_p); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL reset_busy bad_cycles=%0d expected 0", bad_b); end
  endtask

  task automatic test_good_frame();
    logic [WA-1:0] p = 16'hA583;
    int r0 = rdy_cnt_a, pe0 = perr_cnt_a, fe0 = ferr_cnt_a;
    drive_frame(1'b0, ext_a(p), ^p, 1'b1, -1);
    repeat (4) @(negedge clk);
    exp_a = p;
    checks++; if (rdy_cnt_a - r0 != 1) begin errors++; $display("FAIL good_ready got=%0d expected 1", rdy_cnt_a - r0); end
    checks++; if (perr_cnt_a - pe0 + ferr_cnt_a - fe0 != 0) begin errors++; $display("FAIL good_errs got=%0d expected 0", perr_cnt_a - pe0 + ferr_cnt_a - fe0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL good_data got=%h expected %h", data_a, exp_a); end
  endtask

  task automatic test_parity_err();
    logic [WA-1:0] p = 16'hA583;
    int r0 = rdy_cnt_a, pe0 = perr_cnt_a;
    drive_frame(1'b0, ext_a(p), ~(^p), 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (perr_cnt_a - pe0 != 1) begin errors++; $display("FAIL parity_pulse got=%0d expected 1", perr_cnt_a - pe0); end
    checks++; if (rdy_cnt_a - r0 != 0) begin errors++; $display("FAIL parity_ready got=%0d expected 0", rdy_cnt_a - r0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL parity_hold got=%h expected %h", data_a, exp_a); end
  endtask

  task automatic test_frame_err();
    logic [WA-1:0] p = 16'h5A3C;
    int r0 = rdy_cnt_a, pe0 = perr_cnt_a, fe0 = ferr_cnt_a;
    // wrong parity as well: the framing error alone must be reported
    drive_frame(1'b0, ext_a(p), ~(^p), 1'b0, -1);
    repeat (7) @(negedge clk);
    drive_frame(1'b0, ext_a(16'h0000), 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (ferr_cnt_a - fe0 != 1) begin errors++; $display("FAIL frame_pulse got=%0d expected 1", ferr_cnt_a - fe0); end
    checks++; if (perr_cnt_a - pe0 != 0) begin errors++; $display("FAIL frame_no_parity got=%0d expected 0", perr_cnt_a - pe0); end
    checks++; if (rdy_cnt_a - r0 != 0) begin errors++; $display("FAIL frame_wait_idle ready=%0d expected 0", rdy_cnt_a - r0); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_back_idle busy=%b expected 0", busy_a); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL frame_hold got=%h expected %h", data_a, exp_a); end
    drive_frame(1'b0, ext_a(16'h0001), 1'b1, 1'b1, -1);
    repeat (4) @(negedge clk);
    exp_a = 16'h0001;
    checks++; if (rdy_cnt_a - r0 != 1) begin errors++; $display("FAIL frame_recover_ready got=%0d expected 1", rdy_cnt_a - r0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL frame_recover_data got=%h expected %h", data_a, exp_a); end
  endtask

  task automatic test_false_start();
    int r0 = rdy_cnt_a, pe0 = perr_cnt_a, fe0 = ferr_cnt_a;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL false_start_busy got=%b expected 1", busy_a); end
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL false_start_idle busy=%b expected 0", busy_a); end
    checks++; if (rdy_cnt_a - r0 + perr_cnt_a - pe0 + ferr_cnt_a - fe0 != 0) begin errors++; $display("FAIL false_start_pulses got=%0d expected 0", rdy_cnt_a - r0 + perr_cnt_a - pe0 + ferr_cnt_a - fe0); end
    drive_frame(1'b0, ext_a(16'hFFFF), 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    exp_a = 16'hFFFF;
    checks++; if (rdy_cnt_a - r0 != 1) begin errors++; $display("FAIL false_start_next_ready got=%0d expected 1", rdy_cnt_a - r0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL false_start_next_data got=%h expected %h", data_a, exp_a); end
  endtask

  task automatic test_reset_mid_frame();
    int r0 = rdy_cnt_a, pe0 = perr_cnt_a, fe0 = ferr_cnt_a;
    drive_frame(1'b0, ext_a(16'h1234), 1'b1, 1'b1, 8);
    rst_in = 1'b1; rx_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    exp_a = '0;
    checks++; if (rdy_cnt_a - r0 + perr_cnt_a - pe0 + ferr_cnt_a - fe0 != 0) begin errors++; $display("FAIL midreset_pulses got=%0d expected 0", rdy_cnt_a - r0 + perr_cnt_a - pe0 + ferr_cnt_a - fe0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL midreset_data got=%h expected %h", data_a, exp_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b expected 0", busy_a); end
    drive_frame(1'b0, ext_a(16'h1234), ^(16'h1234), 1'b1, -1);
    repeat (4) @(negedge clk);
    exp_a = 16'h1234;
    checks++; if (rdy_cnt_a - r0 != 1) begin errors++; $display("FAIL midreset_next_ready got=%0d expected 1", rdy_cnt_a - r0); end
    checks++; if (data_a !== exp_a) begin errors++; $display("FAIL midreset_next_data got=%h expected %h", data_a, exp_a); end
  endtask

  task automatic test_back_to_back();
    logic [191:0] r1, r2;
    logic [WB-1:0] p1, p2;
    int r0 = rdy_cnt_b, e0 = perr_cnt_b + ferr_cnt_b;
    r1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    p1 = r1[WB-1:0];
    p2 = r2[WB-1:0];
    drive_frame(1'b1, p1, 1'b0, 1'b1, 8);
    rst_in = 1'b1; rx_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    exp_a = '0;
    checks++; if (rdy_cnt_b - r0 != 0) begin errors++; $display("FAIL wide_midreset_ready got=%0d expected 0", rdy_cnt_b - r0); end
    checks++; if (data_b !== '0) begin errors++; $display("FAIL wide_midreset_data got=%h expected 0", data_b); end
    got_b.delete();
    drive_frame(1'b1, p1, 1'b0, 1'b1, -1);
    drive_frame(1'b1, p2, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    checks++; if (rdy_cnt_b - r0 != 2) begin errors++; $display("FAIL wide_b2b_ready got=%0d expected 2", rdy_cnt_b - r0); end
    checks++; if (perr_cnt_b + ferr_cnt_b - e0 != 0) begin errors++; $display("FAIL wide_b2b_errs got=%0d expected 0", perr_cnt_b + ferr_cnt_b - e0); end
    if (got_b.size() == 2) begin
      checks++; if (got_b[0] !== p1) begin errors++; $display("FAIL wide_b2b_first got=%h expected %h", got_b[0], p1); end
      checks++; if (got_b[1] !== p2) begin errors++; $display("FAIL wide_b2b_second got=%h expected %h", got_b[1], p2); end
    end else begin
      checks++; errors++; $display("FAIL wide_b2b_captures got=%0d expected 2", got_b.size());
    end
    checks++; if (data_b !== p2) begin errors++; $display("FAIL wide_b2b_hold got=%h expected %h", data_b, p2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [WA-1:0] p;
      logic par, stop;
      int kind, er, ep, ef;
      int r0 = rdy_cnt_a, pe0 = perr_cnt_a, fe0 = ferr_cnt_a;
      p    = WA'($urandom_range(0, 65535));
      kind = $urandom_range(0, 3);
      par  = (kind == 2) ? ~(^p) : (kind == 3) ? 1'($urandom_range(0, 1)) : ^p;
      stop = (kind != 3);
      er = 0; ep = 0; ef = 0;
      if (!stop) ef = 1;
      else if (par != ^p) ep = 1;
      else begin er = 1; exp_a = p; end
      drive_frame(1'b0, ext_a(p), par, stop, -1);
      repeat (12) @(negedge clk);
      checks++;
      if (rdy_cnt_a - r0 != er || perr_cnt_a - pe0 != ep || ferr_cnt_a - fe0 != ef) begin
        errors++;
        $display("FAIL rand%0d_pulses rdy/perr/ferr=%0d/%0d/%0d expected %0d/%0d/%0d", n,
                 rdy_cnt_a - r0, perr_cnt_a - pe0, ferr_cnt_a - fe0, er, ep, ef);
      end
      checks++; if (data_a !== exp_a) begin errors++; $display("FAIL rand%0d_data got=%h expected %h", n, data_a, exp_a); end
    end
    checks++; if (both_a != 0) begin errors++; $display("FAIL exclusive_pulses got=%0d expected 0", both_a); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_false_start();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
